rgb_hue_sched: RTL and testbench

Scheduler for the three-channel RGB LED fade. It owns the 1 ms step prescaler, a 6-phase hue-wheel state machine that decides per phase whether each colour channel rises, falls, holds high or holds low, and the shared PWM period counter with three duty comparators. It sits between the board clock and the RGB LED pins, replacing per-channel free-running fade cycles with one coordinated, single-clock-domain sequencer.

---
 rtl/rgb_hue_sched_pkg.sv | 64 ++++++
 rtl/rgb_hue_sched_if.sv | 31 +++
 rtl/rgb_hue_sched_tick_prescaler.sv | 35 +++
 rtl/rgb_hue_sched.sv | 129 ++++++++++++
 tb/tb_rgb_hue_sched.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/rgb_hue_sched_pkg.sv
// Shared types for the RGB hue-wheel scheduler: phase and channel-role enums,
// channel indices and the phase/role table.
package rgb_hue_pkg;

    typedef enum logic [2:0] {
        P0,
        P1,
        P2,
        P3,
        P4,
        P5
    } phase_t;

    typedef enum logic [1:0] {
        HIGH,
        LOW,
        RISE,
        FALL
    } role_t;

    localparam int R      = 0;
    localparam int G      = 1;
    localparam int B      = 2;
    localparam int NUM_CH = 3;

    // One row per phase, giving what each colour channel does while it is active.
    function automatic role_t phase_role(phase_t ph, int ch);
        role_t r_role;
        role_t g_role;
        role_t b_role;
        role_t role;
        r_role = LOW;
        g_role = LOW;
        b_role = LOW;
        case (ph)
            P0: begin r_role = HIGH; g_role = RISE; b_role = LOW;  end
            P1: begin r_role = FALL; g_role = HIGH; b_role = LOW;  end
            P2: begin r_role = LOW;  g_role = HIGH; b_role = RISE; end
            P3: begin r_role = LOW;  g_role = FALL; b_role = HIGH; end
            P4: begin r_role = RISE; g_role = LOW;  b_role = HIGH; end
            P5: begin r_role = HIGH; g_role = LOW;  b_role = FALL; end
            default: begin r_role = LOW; g_role = LOW; b_role = LOW; end
        endcase
        if (ch == R) begin
            role = r_role;
        end else if (ch == G) begin
            role = g_role;
        end else begin
            role = b_role;
        end
        return role;
    endfunction

    function automatic phase_t next_phase(phase_t ph);
        phase_t nxt;
        if (ph == P5) begin
            nxt = P0;
        end else begin
            nxt = phase_t'(ph + 3'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_hue_sched_if.sv
// Bus between the hue scheduler and its consumer: fade enable in,
// PWM pins and fade status out.
interface rgb_hue_sched_if #(
    parameter int DUTY_W = 11
);

    logic              en;
    logic              pwm_r;
    logic              pwm_g;
    logic              pwm_b;
    logic [DUTY_W-1:0] duty_r;
    logic [DUTY_W-1:0] duty_g;
    logic [DUTY_W-1:0] duty_b;
    logic [2:0]        phase;
    logic              phase_done;

    modport master (
        input  en,
        output pwm_r, pwm_g, pwm_b,
        output duty_r, duty_g, duty_b,
        output phase, phase_done
    );

    modport slave (
        output en,
        input  pwm_r, pwm_g, pwm_b,
        input  duty_r, duty_g, duty_b,
        input  phase, phase_done
    );

endinterface

// File: rtl/rgb_hue_sched_tick_prescaler.sv
// Step-tick prescaler: counts enabled clock cycles and emits a registered
// one-cycle tick on each wrap; the count holds while disabled.
module tick_prescaler #(
    parameter int TICK_INTERVAL = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = (TICK_INTERVAL > 1) ? $clog2(TICK_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_INTERVAL - 1);

    logic [CNT_W-1:0] count;
    logic             wrap;

    assign wrap = en && (count == LAST);

    // Tick is registered, so a tick already issued is applied even if en drops next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                count <= '0;
            end else if (en) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_hue_sched.sv
// Coordinated RGB hue-wheel fade: step prescaler, 6-phase role sequencer,
// per-channel ramping duty and a shared glitch-free PWM period counter.
module rgb_hue_sched
    import rgb_hue_pkg::*;
#(
    parameter int TICK_INTERVAL = 12000,
    parameter int STEPS         = 300,
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEP_VAL      = PWM_INTERVAL / STEPS,
    parameter int DUTY_W        = $clog2(PWM_INTERVAL + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    rgb_hue_sched_if.master bus
);

    localparam int                STEP_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int                PWM_W    = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam logic [STEP_W-1:0] STEP_END = STEP_W'(STEPS - 1);
    localparam logic [PWM_W-1:0]  PWM_END  = PWM_W'(PWM_INTERVAL - 1);
    localparam logic [DUTY_W-1:0] FULL     = DUTY_W'(PWM_INTERVAL);
    localparam logic [DUTY_W:0]   FULL_EXT = (DUTY_W + 1)'(PWM_INTERVAL);
    localparam logic [DUTY_W-1:0] STEP_D   = DUTY_W'(STEP_VAL);
    localparam logic [DUTY_W:0]   STEP_EXT = (DUTY_W + 1)'(STEP_VAL);

    logic              tick;
    phase_t            phase_q;
    logic [STEP_W-1:0] step_q;
    logic              phase_done_q;
    logic              last_step;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [DUTY_W-1:0] duty [NUM_CH];
    logic              pwm  [NUM_CH];

    tick_prescaler #(
        .TICK_INTERVAL(TICK_INTERVAL)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.en),
        .tick (tick)
    );

    assign last_step = (step_q == STEP_END);

    // Hue-wheel sequencer: counts ticks within a phase and advances on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= P0;
            step_q       <= '0;
            phase_done_q <= 1'b0;
        end else begin
            phase_done_q <= 1'b0;
            if (tick) begin
                if (last_step) begin
                    step_q       <= '0;
                    phase_q      <= next_phase(phase_q);
                    phase_done_q <= 1'b1;
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

    // PWM period counter free-runs regardless of en so the LEDs keep lighting while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_END) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DUTY_W-1:0] duty_q;
        logic [DUTY_W-1:0] duty_next;
        logic [DUTY_W:0]   raised;
        logic [DUTY_W-1:0] shadow;
        logic              pwm_q;

        // The last step of a phase snaps a ramp to its endpoint so rounding never accumulates.
        always_comb begin
            raised    = {1'b0, duty_q} + STEP_EXT;
            duty_next = duty_q;
            case (phase_role(phase_q, i))
                RISE:    duty_next = (last_step || raised >= FULL_EXT) ? FULL : raised[DUTY_W-1:0];
                FALL:    duty_next = (last_step || duty_q <= STEP_D) ? '0 : duty_q - STEP_D;
                default: duty_next = duty_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty_q <= (i == R) ? FULL : '0;
            end else if (tick) begin
                duty_q <= duty_next;
            end
        end

        // Shadow only reloads at the period boundary, so a duty change never splits a pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (pwm_cnt == '0) begin
                    shadow <= duty_q;
                end
                pwm_q <= (DUTY_W'(pwm_cnt) < shadow);
            end
        end

        assign duty[i] = duty_q;
        assign pwm[i]  = pwm_q;
    end

    assign bus.duty_r     = duty[R];
    assign bus.duty_g     = duty[G];
    assign bus.duty_b     = duty[B];
    assign bus.pwm_r      = pwm[R];
    assign bus.pwm_g      = pwm[G];
    assign bus.pwm_b      = pwm[B];
    assign bus.phase      = phase_q;
    assign bus.phase_done = phase_done_q;

endmodule

// File: tb/tb_rgb_hue_sched.sv
// Directed bench for rgb_hue_sched with a 4-cycle tick, 3 steps per phase
// and a 12-cycle PWM period; edges are counted from reset release.
module tb_rgb_hue_sched;

    logic clk = 1'b0;
    logic rst_n;

    rgb_hue_sched_if #(.DUTY_W(4)) bus ();

    rgb_hue_sched #(
        .TICK_INTERVAL(4),
        .STEPS        (3),
        .PWM_INTERVAL (12),
        .STEP_VAL     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int cnt_r    = 0;
    int cnt_g    = 0;
    int cnt_b    = 0;
    int done_cnt = 0;

    // Hand-derived duties (R,G,B) after the first and second tick of each phase,
    // and at the boundary that ends it.
    int exp_tick1 [6][3] = '{'{12, 4, 0}, '{8, 12, 0}, '{0, 12, 4},
                             '{0, 8, 12}, '{4, 0, 12}, '{12, 0, 8}};
    int exp_tick2 [6][3] = '{'{12, 8, 0}, '{4, 12, 0}, '{0, 12, 8},
                             '{0, 4, 12}, '{8, 0, 12}, '{12, 0, 4}};
    int exp_end   [6][3] = '{'{12, 12, 0}, '{0, 12, 0}, '{0, 12, 12},
                             '{0, 0, 12},  '{12, 0, 12}, '{12, 0, 0}};

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_duties(input string tag, input int r, input int g, input int b);
        check_output({tag, ".duty_r"}, 32'(bus.duty_r), r);
        check_output({tag, ".duty_g"}, 32'(bus.duty_g), g);
        check_output({tag, ".duty_b"}, 32'(bus.duty_b), b);
    endtask

    task automatic clear_counts();
        cnt_r    = 0;
        cnt_g    = 0;
        cnt_b    = 0;
        done_cnt = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            edge_n++;
            cnt_r    += int'(bus.pwm_r);
            cnt_g    += int'(bus.pwm_g);
            cnt_b    += int'(bus.pwm_b);
            done_cnt += int'(bus.phase_done);
        end
    endtask

    task automatic run_to(input int target);
        run(target - edge_n);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, ".phase"}, 32'(bus.phase), 0);
        check_duties(tag, 12, 0, 0);
        check_output({tag, ".pwm_r"}, 32'(bus.pwm_r), 0);
        check_output({tag, ".pwm_g"}, 32'(bus.pwm_g), 0);
        check_output({tag, ".pwm_b"}, 32'(bus.pwm_b), 0);
        check_output({tag, ".phase_done"}, 32'(bus.phase_done), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        check_reset_values("in_reset");

        rst_n  = 1'b1;
        edge_n = 0;
        run(1);
        check_output("pwm_r_edge1", 32'(bus.pwm_r), 0);
        clear_counts();
        run_to(4);
        check_output("duty_g_before_tick", 32'(bus.duty_g), 0);

        $display("[TB] full wheel");
        for (int p = 0; p < 6; p++) begin
            run_to(12 * p + 5);
            check_duties($sformatf("p%0d_tick1", p), exp_tick1[p][0], exp_tick1[p][1], exp_tick1[p][2]);
            run_to(12 * p + 9);
            check_duties($sformatf("p%0d_tick2", p), exp_tick2[p][0], exp_tick2[p][1], exp_tick2[p][2]);
            run_to(12 * p + 12);
            check_output($sformatf("p%0d_phase_hold", p), 32'(bus.phase), p);
            check_output($sformatf("p%0d_done_low", p), 32'(bus.phase_done), 0);
            run_to(12 * p + 13);
            check_output($sformatf("p%0d_phase_next", p), 32'(bus.phase), (p + 1) % 6);
            check_output($sformatf("p%0d_done_pulse", p), 32'(bus.phase_done), 1);
            check_duties($sformatf("p%0d_end", p), exp_end[p][0], exp_end[p][1], exp_end[p][2]);
            if (p == 0) begin
                check_output("p0_pwm_r_highs", cnt_r, 12);
                check_output("p0_pwm_g_highs", cnt_g, 0);
                check_output("p0_pwm_b_highs", cnt_b, 0);
                check_output("p0_done_pulses", done_cnt, 1);
                run(1);
                check_output("p0_done_drop", 32'(bus.phase_done), 0);
            end
        end
        check_output("wheel_done_pulses", done_cnt, 6);

        $display("[TB] freeze during P2");
        run_to(98);
        check_output("pre_freeze_phase", 32'(bus.phase), 2);
        bus.en = 1'b0;
        clear_counts();
        run_to(148);
        check_output("frozen_phase", 32'(bus.phase), 2);
        check_duties("frozen", 0, 12, 0);
        check_output("frozen_pwm_g_highs", cnt_g, 50);
        check_output("frozen_pwm_b_highs", cnt_b, 0);
        check_output("frozen_done_pulses", done_cnt, 0);
        bus.en = 1'b1;
        run_to(150);
        check_output("resume_before_tick", 32'(bus.duty_b), 0);
        run_to(151);
        check_output("resume_first_tick", 32'(bus.duty_b), 4);

        $display("[TB] reset during P4 tick cycle");
        run_to(174);
        check_output("p4_phase", 32'(bus.phase), 4);
        check_duties("p4_pre_reset", 0, 0, 12);
        check_output("p4_pwm_b", 32'(bus.pwm_b), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");

        $display("[TB] duty change mid period");
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        clear_counts();
        run(6);
        bus.en = 1'b1;
        run_to(10);
        check_output("late_duty_g_pre", 32'(bus.duty_g), 0);
        run_to(11);
        check_output("late_duty_g_tick", 32'(bus.duty_g), 4);
        run_to(13);
        check_output("current_period_g_highs", cnt_g, 0);
        clear_counts();
        run_to(14);
        check_output("next_period_g_first", 32'(bus.pwm_g), 1);
        run_to(25);
        check_output("next_period_g_highs", cnt_g, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
